// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and FSM state encoding for the memory arbiter.
package mem_arb_pkg;
   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 4096;
   typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant with a last-grant pointer.
module rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_req0,
   input  logic i_req1,
   output logic o_gnt0,
   output logic o_gnt1
);
   logic r_last;
   // r_last=1 means port 1 was granted most recently, so port 0 wins a conflict
   assign o_gnt0 = i_en & i_req0 & (~i_req1 | r_last);
   assign o_gnt1 = i_en & i_req1 & ~o_gnt0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_last <= 1'b1;
      else if (o_gnt0) r_last <= 1'b0;
      else if (o_gnt1) r_last <= 1'b1;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-requester arbiter onto one memory port, with optional zero-fill after reset.
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] dout0,
   output logic [DATA_W-1:0] dout1,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              init_done,
   output logic [15:0]       conflict_cnt
);
   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic [15:0]       r_conf;
   logic              r_rv0, r_rv1;
   logic              w_run;

   assign w_run = (r_state == RUN);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_run),
      .i_req0 (req0),
      .i_req1 (req1),
      .o_gnt0 (gnt0),
      .o_gnt1 (gnt1)
   );

   // rst_n gating keeps the fill strobe low while reset is held
   assign mem_we   = w_run ? ((gnt0 & we0) | (gnt1 & we1)) : ((CLEAR_ON_RESET != 0) & rst_n);
   assign mem_addr = w_run ? (gnt0 ? addr0 : gnt1 ? addr1 : '0) : r_cnt;
   assign mem_din  = w_run ? (gnt0 ? din0 : gnt1 ? din1 : '0) : '0;

   assign dout0        = mem_dout;
   assign dout1        = mem_dout;
   assign rvalid0      = r_rv0;
   assign rvalid1      = r_rv1;
   assign init_done    = w_run;
   assign conflict_cnt = r_conf;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= INIT;
         r_cnt   <= '0;
         r_conf  <= '0;
         r_rv0   <= 1'b0;
         r_rv1   <= 1'b0;
      end else begin
         r_rv0 <= gnt0 & ~we0;
         r_rv1 <= gnt1 & ~we1;
         if (!w_run) begin
            r_cnt <= r_cnt + 1'b1;
            if (CLEAR_ON_RESET == 0 || r_cnt == ADDR_W'(MEM_DEPTH - 1)) r_state <= RUN;
         end else if (req0 && req1 && r_conf != 16'hFFFF) begin
            r_conf <= r_conf + 16'd1;
         end
      end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb with a behavioural memory.
module tb_mem_arb;
   logic        clk = 1'b0, rst_n = 1'b1;
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [11:0] addr0 = 0, addr1 = 0;
   logic [31:0] din0 = 0, din1 = 0;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_we, init_done;
   logic [31:0] dout0, dout1, mem_din, mem_dout;
   logic [11:0] mem_addr;
   logic [15:0] conflict_cnt;
   logic [31:0] mem [4096];
   int pass_cnt = 0, tot_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      mem_dout <= mem[mem_addr];
   end

   mem_arb #(.CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .dout0(dout0), .dout1(dout1), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .init_done(init_done),
      .conflict_cnt(conflict_cnt)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      req0 = 1; req1 = 1; addr0 = 12'h005; addr1 = 12'h006;
      #3 rst_n = 0;
      @(negedge clk);
      tot_cnt++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL rst_gnt got=%b exp=00", {gnt0, gnt1}); else pass_cnt++;
      tot_cnt++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL rst_rvalid got=%b exp=00", {rvalid0, rvalid1}); else pass_cnt++;
      tot_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else pass_cnt++;
      tot_cnt++; if (mem_addr !== 12'h000) $display("FAIL rst_mem_addr got=%h exp=000", mem_addr); else pass_cnt++;
      tot_cnt++; if (init_done !== 1'b0) $display("FAIL rst_init_done got=%b exp=0", init_done); else pass_cnt++;
      tot_cnt++; if (conflict_cnt !== 16'h0) $display("FAIL rst_conflict got=%h exp=0000", conflict_cnt); else pass_cnt++;
      step();
      req1 = 0;
      rst_n = 1;
   endtask

   task automatic test_init_fill(input string tag);
      int errs = 0;
      for (int i = 0; i < 4096; i++) begin
         @(negedge clk);
         if (mem_we !== 1'b1 || mem_addr !== 12'(i) || mem_din !== 32'h0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || init_done !== 1'b0) begin
            if (errs == 0) $display("FAIL %s_seq cycle=%0d got we=%b addr=%h din=%h gnt=%b%b done=%b exp we=1 addr=%h din=0 gnt=00 done=0",
                                    tag, i, mem_we, mem_addr, mem_din, gnt0, gnt1, init_done, 12'(i));
            errs++;
         end
      end
      tot_cnt++; if (errs != 0) $display("FAIL %s_seq errors got=%0d exp=0", tag, errs); else pass_cnt++;
      @(negedge clk);
      tot_cnt++; if (init_done !== 1'b1) $display("FAIL %s_done got=%b exp=1", tag, init_done); else pass_cnt++;
   endtask

   task automatic test_first_grant;
      tot_cnt++; if ({gnt0, gnt1, mem_we, mem_addr} !== {3'b100, 12'h005}) $display("FAIL first_grant got=%b%b%b %h exp=100 005", gnt0, gnt1, mem_we, mem_addr); else pass_cnt++;
      step();
      req0 = 0;
      @(negedge clk);
      tot_cnt++; if ({rvalid0, rvalid1, dout0} !== {2'b10, 32'h0}) $display("FAIL first_read got=%b%b %h exp=10 00000000", rvalid0, rvalid1, dout0); else pass_cnt++;
      step();
   endtask

   task automatic test_writes;
      for (int i = 0; i < 6; i++) begin
         req0 = 1; we0 = 1; addr0 = 12'h020 + 12'(i); din0 = 32'h1000 + 32'(i);
         @(negedge clk);
         tot_cnt++;
         if ({gnt0, gnt1, mem_we, mem_addr, mem_din} !== {3'b101, 12'h020 + 12'(i), 32'h1000 + 32'(i)})
            $display("FAIL wr_%0d got=%b%b%b %h %h exp=101 %h %h", i, gnt0, gnt1, mem_we, mem_addr, mem_din, 12'h020 + 12'(i), 32'h1000 + 32'(i));
         else pass_cnt++;
         step();
      end
      req0 = 0; we0 = 0;
   endtask

   task automatic test_raw;
      req0 = 1; we0 = 1; addr0 = 12'h010; din0 = 32'hDEADBEEF;
      @(negedge clk);
      tot_cnt++; if ({gnt0, gnt1, mem_we} !== 3'b101) $display("FAIL raw_wr got=%b%b%b exp=101", gnt0, gnt1, mem_we); else pass_cnt++;
      step();
      req0 = 0; we0 = 0; req1 = 1; we1 = 0; addr1 = 12'h010;
      @(negedge clk);
      tot_cnt++; if ({gnt0, gnt1, mem_we, rvalid0, rvalid1, mem_addr} !== {5'b01000, 12'h010}) $display("FAIL raw_rd got=%b%b%b%b%b %h exp=01000 010", gnt0, gnt1, mem_we, rvalid0, rvalid1, mem_addr); else pass_cnt++;
      step();
      req1 = 0;
      @(negedge clk);
      tot_cnt++; if ({rvalid0, rvalid1, dout1} !== {2'b01, 32'hDEADBEEF}) $display("FAIL raw_data got=%b%b %h exp=01 deadbeef", rvalid0, rvalid1, dout1); else pass_cnt++;
      step();
      @(negedge clk);
      tot_cnt++; if ({rvalid0, rvalid1} !== 2'b00) $display("FAIL raw_one_shot got=%b%b exp=00", rvalid0, rvalid1); else pass_cnt++;
      step();
   endtask

   task automatic test_round_robin;
      int n0 = 0, n1 = 0, prev = -1;
      logic [11:0] prev_addr = 0;
      for (int k = 0; k < 7; k++) begin
         req0 = (n0 < 3); addr0 = 12'h020 + 12'(2 * n0);
         req1 = (n1 < 3); addr1 = 12'h021 + 12'(2 * n1);
         @(negedge clk);
         if (k < 6) begin
            tot_cnt++;
            if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL rr_gnt_%0d got=%b%b exp=%b", k, gnt0, gnt1, (k % 2 == 0) ? 2'b10 : 2'b01);
            else pass_cnt++;
         end
         if (prev >= 0) begin
            tot_cnt++;
            if ({rvalid0, rvalid1, mem_dout} !== {(prev == 0), (prev == 1), 32'h1000 + 32'(prev_addr - 12'h020)})
               $display("FAIL rr_rvalid_%0d got=%b%b %h exp=%b%b %h", k, rvalid0, rvalid1, mem_dout, prev == 0, prev == 1, 32'h1000 + 32'(prev_addr - 12'h020));
            else pass_cnt++;
         end
         prev = (k >= 6) ? -1 : (k % 2);
         prev_addr = (k % 2 == 0) ? addr0 : addr1;
         if (k % 2 == 0) n0++; else n1++;
         step();
      end
      req0 = 0; req1 = 0;
      @(negedge clk);
      tot_cnt++; if (conflict_cnt !== 16'd5) $display("FAIL rr_conflict got=%0d exp=5", conflict_cnt); else pass_cnt++;
      step();
   endtask

   task automatic test_saturate;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
      repeat (65529) @(posedge clk);
      @(negedge clk);
      tot_cnt++; if (conflict_cnt !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", conflict_cnt); else pass_cnt++;
      repeat (4471) @(posedge clk);
      @(negedge clk);
      tot_cnt++; if (conflict_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt); else pass_cnt++;
      req0 = 0; req1 = 0;
      step();
   endtask

   task automatic test_reset_mid;
      int errs = 0;
      req0 = 1; addr0 = 12'h020;
      @(negedge clk);
      tot_cnt++; if (gnt0 !== 1'b1) $display("FAIL rv_gnt got=%b exp=1", gnt0); else pass_cnt++;
      step();
      req0 = 0;
      rst_n = 0;
      #1;
      tot_cnt++; if ({rvalid0, rvalid1, conflict_cnt} !== 18'h0) $display("FAIL rv_reset got=%b%b %h exp=00 0000", rvalid0, rvalid1, conflict_cnt); else pass_cnt++;
      step();
      rst_n = 1;
      for (int i = 0; i < 12'h800; i++) begin
         @(negedge clk);
         if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || mem_addr !== 12'(i)) errs++;
      end
      tot_cnt++; if (errs != 0) $display("FAIL rv_after_reset errors got=%0d exp=0", errs); else pass_cnt++;
      @(negedge clk);
      tot_cnt++; if (mem_addr !== 12'h800) $display("FAIL mid_addr got=%h exp=800", mem_addr); else pass_cnt++;
      rst_n = 0;
      #1;
      tot_cnt++; if ({mem_we, mem_addr, init_done} !== 14'h0) $display("FAIL mid_abort got=%b %h %b exp=0 000 0", mem_we, mem_addr, init_done); else pass_cnt++;
      step();
      rst_n = 1;
      test_init_fill("refill");
   endtask

   initial begin
      test_reset();
      test_init_fill("init");
      test_first_grant();
      test_writes();
      test_raw();
      test_round_robin();
      test_saturate();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1: zero-fill all 4096 memory words after reset before serving requests.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 reqN (N=0,1)  input  1  requester N access request; held until granted.
REQ-005 weN  input  1  requester N write (1) / read (0).
REQ-006 addrN  input  12  requester N word address.
REQ-007 dinN  input  32  requester N write data.
REQ-008 gntN  output  1  requester N granted this cycle (combinational).
REQ-009 rvalidN  output  1  doutN carries read data for requester N.
REQ-010 doutN  output  32  read data; equals mem_dout; meaningful only while rvalidN=1.
REQ-011 mem_we / mem_addr / mem_din  output  1/12/32  single shared memory port (synchronous write, registered read, 1-cycle latency).
REQ-012 mem_dout  input  32  memory read data.
REQ-013 init_done  output  1  high once the block is serving requests.
REQ-014 conflict_cnt  output  16  count of cycles in which a request was denied due to contention.

Function
REQ-015 FSM states INIT and RUN; reset enters INIT.
REQ-016 INIT with CLEAR_ON_RESET=1: mem_we=1, mem_din=0, mem_addr = 12-bit counter from 0 incrementing by 1 per cycle; after address 4095 is written, go to RUN (4096 INIT cycles total).
REQ-017 INIT with CLEAR_ON_RESET=0: go to RUN on the first clock edge after reset release, with no memory writes.
REQ-018 init_done is registered: 0 in INIT, 1 from the first RUN cycle onward.
REQ-019 In INIT, gnt0=gnt1=0 and all requests are ignored.
REQ-020 In RUN, at most one gntN per cycle; a transaction occurs in a cycle where reqN and gntN are both 1.
REQ-021 Sole requester is granted in the same cycle.
REQ-022 When both request, grant the port not granted most recently; the last-grant pointer updates on every grant.
REQ-023 Any continuously asserted request is granted within 2 cycles.
REQ-024 In RUN, mem_we/mem_addr/mem_din drive the granted port's weN/addrN/dinN; with no grant, mem_we=0 and mem_addr=0.
REQ-025 A granted read in cycle n asserts rvalidN for exactly cycle n+1; back-to-back reads yield back-to-back rvalid.
REQ-026 A granted write produces no rvalid.
REQ-027 A write in cycle n followed by a read of the same address in cycle n+1 (either port) returns the new data.
REQ-028 conflict_cnt increments by 1 in each RUN cycle with req0=req1=1 and saturates at 0xFFFF.

Reset
REQ-029 While rst_n=0, outputs SHALL be: gntN=0, rvalidN=0, mem_we=0, mem_addr=0, init_done=0, conflict_cnt=0; the last-grant pointer resets to port 1 so port 0 wins the first conflict.
REQ-030 Reset asserted mid-INIT aborts the fill, clears the counter to 0, and restarts INIT from address 0 after release.
REQ-031 Reset asserted in RUN discards any pending rvalid; no rvalid is issued after release.

Structure
REQ-032 Package mem_arb_pkg SHALL hold ADDR_W=12, DATA_W=32, MEM_DEPTH=4096 and the state enum {INIT, RUN}.
REQ-033 Two-way round-robin grant logic plus pointer SHALL be a sub-module rr_arb2; counters, FSM and port mux stay in mem_arb.

Verification
REQ-034 Reset release with CLEAR_ON_RESET=1 -> mem_we high for 4096 cycles, addresses 0..4095 with data 0, then init_done=1; req0 held throughout is granted on the first RUN cycle.
REQ-035 RUN: port0 writes 0xDEADBEEF to 0x010; next cycle port1 reads 0x010 -> rvalid1 one cycle later with dout1=0xDEADBEEF and rvalid0=0.
REQ-036 req0 and req1 both held for 6 reads -> grants alternate 0,1,0,1,0,1, rvalids alternate the cycle after, and conflict_cnt increments per contended cycle (5 cycles, final value 5).
REQ-037 Hold both requests for 70000 cycles -> conflict_cnt saturates at 0xFFFF and does not wrap.
REQ-038 Assert rst_n=0 at INIT address 0x800 -> after release, INIT restarts at address 0 and runs a full 4096 cycles; assert reset one cycle after a granted read -> no rvalid is seen.
